// File: rtl/switch_scheduler_pkg.sv
// Shared constants and the per-input holding entry for the 4-port switch scheduler.
// The stats counters are built only with SWITCH_SCHED_STATS_EN.
package switch_scheduler_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_W-1:0]    source;
        logic [ADDR_W-1:0]    target;
        logic [NUM_PORTS-1:0] pend;
        logic [DATA_W-1:0]    data;
    } hold_entry_t;

endpackage

// File: rtl/switch_scheduler_if.sv
// Packet ingress/egress bundle between the port logic and the scheduler.
interface switch_scheduler_if #(
    parameter int NUM_PORTS = switch_scheduler_pkg::NUM_PORTS,
    parameter int ADDR_W    = switch_scheduler_pkg::ADDR_W,
    parameter int DATA_W    = switch_scheduler_pkg::DATA_W
);
    import switch_scheduler_pkg::*;

    logic [NUM_PORTS-1:0]             in_valid;
    logic [NUM_PORTS-1:0]             in_ready;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_source;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_target;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]             out_valid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] out_source;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] out_target;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_source, in_target, in_data,
        input  in_ready, out_valid, out_source, out_target, out_data
    );

    modport slave (
        input  in_valid, in_source, in_target, in_data,
        output in_ready, out_valid, out_source, out_target, out_data
    );

endinterface

// File: rtl/switch_scheduler_rr_arbiter.sv
// N-way round-robin arbiter; the search starts one past the last granted index.
module rr_arbiter #(
    parameter int N = switch_scheduler_pkg::NUM_PORTS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output logic         gnt_valid
);
    import switch_scheduler_pkg::*;

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    int            idx;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    // Reset to the last index so input 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= IW'(N - 1);
        else if (adv && gnt_valid)
            ptr <= gnt_idx;
    end

endmodule

// File: rtl/switch_scheduler.sv
// Output-port scheduler: one holding entry per input, one round-robin arbiter per output.
// Build with SWITCH_SCHED_STATS_EN to add the grant_cnt/drop_cnt counters.
module switch_scheduler #(
    parameter int NUM_PORTS = switch_scheduler_pkg::NUM_PORTS,
    parameter int ADDR_W    = switch_scheduler_pkg::ADDR_W,
    parameter int DATA_W    = switch_scheduler_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    switch_scheduler_if.slave     bus
`ifdef SWITCH_SCHED_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][15:0] grant_cnt,
    output logic [15:0]                drop_cnt
`endif
);
    import switch_scheduler_pkg::*;

    hold_entry_t hold [NUM_PORTS];
    hold_entry_t sel  [NUM_PORTS];

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;   // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;   // [output][input], one-hot per output
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] won;   // [input][output]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] left;  // [input] pend bits still unserved after this cycle
    logic [NUM_PORTS-1:0]                gvld;
    logic [NUM_PORTS-1:0]                ready;
    logic [NUM_PORTS-1:0]                accept;
    logic [NUM_PORTS-1:0]                drop;

    always_comb begin
        req = '0;
        for (int j = 0; j < NUM_PORTS; j++)
            for (int i = 0; i < NUM_PORTS; i++)
                req[j][i] = hold[i].valid & hold[i].pend[j];
    end

    rr_arbiter #(.N(NUM_PORTS)) u_arb [NUM_PORTS-1:0] (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .adv       ({NUM_PORTS{1'b1}}),
        .gnt       (gnt),
        .gnt_valid (gvld)
    );

    // Ready depends only on state and this cycle's grants, never on in_valid.
    always_comb begin
        won   = '0;
        left  = '0;
        ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++)
                won[i][j] = gnt[j][i];
            left[i]  = hold[i].pend & ~won[i];
            ready[i] = ~hold[i].valid | ~|left[i];
        end
    end

    assign bus.in_ready = ready;
    assign accept       = bus.in_valid & ready;

    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            drop[i] = accept[i] & (bus.in_target[i] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++)
                hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (drop[i]) begin
                    hold[i].valid <= 1'b0;
                    hold[i].pend  <= '0;
                end else if (accept[i]) begin
                    hold[i] <= '{valid:  1'b1,
                                 source: bus.in_source[i],
                                 target: bus.in_target[i],
                                 pend:   bus.in_target[i][NUM_PORTS-1:0],
                                 data:   bus.in_data[i]};
                end else if (hold[i].valid) begin
                    hold[i].pend <= left[i];
                    if (~|left[i])
                        hold[i].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            sel[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                if (gnt[j][i])
                    sel[j] = hold[i];
        end
    end

    // Data fields keep their last value when an output is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= '0;
            bus.out_source <= '0;
            bus.out_target <= '0;
            bus.out_data   <= '0;
        end else begin
            bus.out_valid <= gvld;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (gvld[j]) begin
                    bus.out_source[j] <= sel[j].source;
                    bus.out_target[j] <= sel[j].target;
                    bus.out_data[j]   <= sel[j].data;
                end
            end
        end
    end

`ifdef SWITCH_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++)
                if (gvld[j])
                    grant_cnt[j] <= grant_cnt[j] + 16'd1;
            drop_cnt <= drop_cnt + 16'($countones(drop));
        end
    end
`endif

endmodule
